// File: rtl/cam_frame_capture.sv
// -----------------------------------------------------------------------------
// cam_frame_capture
//
// Capture front end for an OV76xx-style parallel camera port. The sensor
// pins are registered once (stage S1). Frames are framed by Vsyn, lines by
// Href. Bytes are packed BPP to a pixel, first byte in the MSBs. Only pixels
// inside the crop window are written to the downstream pixel FIFO.
//
// Pipeline: a byte present at edge k lands in S1. At edge k+1 the packer
// completes the pixel and flags it as pending. At edge k+2 the pending pixel
// is either written (fifo_wr pulse) or dropped because fifo_full is high.
//
// Parameters
//   DW     sensor data width (bits)
//   BPP    bytes per pixel
//   CW     column/row counter width (counters saturate at 2^CW-1)
//   X0,Y0  first captured column / line (0-based)
//   WIN_W  crop window width  (pixels)
//   WIN_H  crop window height (lines)
//
// Ports
//   Pclk        pixel clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   capture     level: 1 = armed, 0 = abort / idle
//   mode        0 = single frame, 1 = continuous (latched when arming)
//   Vsyn        sensor vsync, high during vertical blanking
//   Href        sensor line valid
//   data        sensor byte
//   fifo_full   downstream FIFO full
//   fifo_wr     one-cycle write strobe per stored pixel
//   fifo_data   packed pixel, held until the next write
//   PWDN        sensor power-down, the inverse of capture
//   busy        high while waiting for or capturing a frame
//   frame_done  one-cycle pulse at the end of each completed frame
//   overflow    sticky: a window pixel was dropped due to fifo_full
//   frame_cnt   completed frames since reset, wraps at 255
// -----------------------------------------------------------------------------
module cam_frame_capture #(
  parameter int DW    = 8,
  parameter int BPP   = 2,
  parameter int CW    = 11,
  parameter int X0    = 0,
  parameter int Y0    = 0,
  parameter int WIN_W = 640,
  parameter int WIN_H = 480
) (
  input  logic                Pclk,
  input  logic                rst,
  input  logic                capture,
  input  logic                mode,
  input  logic                Vsyn,
  input  logic                Href,
  input  logic [DW-1:0]       data,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [BPP*DW-1:0]   fifo_data,
  output logic                PWDN,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic [7:0]          frame_cnt
);

  localparam int PW = BPP * DW;
  localparam int IW = (BPP > 1) ? $clog2(BPP) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(BPP - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // Window bounds as unsigned 32-bit values; the window test uses an offset
  // subtraction so positions left of / above the window wrap to a huge value.
  localparam logic [31:0] X0_U    = 32'(X0);
  localparam logic [31:0] Y0_U    = 32'(Y0);
  localparam logic [31:0] WIN_W_U = 32'(WIN_W);
  localparam logic [31:0] WIN_H_U = 32'(WIN_H);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_VS    = 3'd1;
  localparam logic [2:0] ST_WAIT_FRAME = 3'd2;
  localparam logic [2:0] ST_ACTIVE     = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  // Stage S1 and previous-S1 copies for edge detection
  logic          vsyn_s1_q, vsyn_s1_d;
  logic          href_s1_q, href_s1_d;
  logic [DW-1:0] data_s1_q, data_s1_d;
  logic          vsyn_p_q,  vsyn_p_d;
  logic          href_p_q,  href_p_d;

  // Control state
  logic [2:0]    state_q, state_d;
  logic          mode_q,  mode_d;
  logic [CW-1:0] col_q,   col_d;
  logic [CW-1:0] row_q,   row_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic [PW-1:0] pack_q,  pack_d;
  logic          wr_pend_q, wr_pend_d;

  // Registered outputs
  logic          fifo_wr_q,    fifo_wr_d;
  logic [PW-1:0] fifo_data_q,  fifo_data_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q,   overflow_d;
  logic [7:0]    frame_cnt_q,  frame_cnt_d;

  logic          vsyn_rise;
  logic          vsyn_fall;
  logic          href_fall;
  logic [31:0]   col_off;
  logic [31:0]   row_off;
  logic          in_win;

  assign vsyn_rise =  vsyn_s1_q & ~vsyn_p_q;
  assign vsyn_fall = ~vsyn_s1_q &  vsyn_p_q;
  assign href_fall = ~href_s1_q &  href_p_q;

  // Window test on the column/row of the pixel currently being completed.
  assign col_off = 32'(col_q) - X0_U;
  assign row_off = 32'(row_q) - Y0_U;
  assign in_win  = (col_off < WIN_W_U) && (row_off < WIN_H_U);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    vsyn_s1_d    = Vsyn;
    href_s1_d    = Href;
    data_s1_d    = data;
    vsyn_p_d     = vsyn_s1_q;
    href_p_d     = href_s1_q;

    state_d      = state_q;
    mode_d       = mode_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    pack_d       = pack_q;
    wr_pend_d    = 1'b0;

    fifo_wr_d    = 1'b0;
    fifo_data_d  = fifo_data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    frame_cnt_d  = frame_cnt_q;

    // Output stage: the pixel completed last cycle is written or dropped.
    // This runs whatever the FSM state, so a pixel that completes together
    // with the frame-ending Vsyn rise still reaches the FIFO.
    if (wr_pend_q) begin
      if (fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        fifo_wr_d   = 1'b1;
        fifo_data_d = pack_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d    = ST_WAIT_VS;
          mode_d     = mode;
          overflow_d = 1'b0;
        end
      end

      // Wait for blanking to start, so arming mid-frame never captures the
      // tail of a frame already in progress.
      ST_WAIT_VS: begin
        if (vsyn_rise) begin
          state_d = ST_WAIT_FRAME;
        end
      end

      ST_WAIT_FRAME: begin
        if (vsyn_fall) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
        end
      end

      ST_ACTIVE: begin
        if (href_s1_q) begin
          // Shift left so the first byte of a pixel ends up in the MSBs.
          pack_d = PW'({pack_q, data_s1_q});
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            wr_pend_d = in_win;
            col_d     = (col_q == CNT_MAX) ? col_q : col_q + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (href_fall) begin
          // Leftover bytes of an incomplete pixel are discarded here.
          row_d = (row_q == CNT_MAX) ? row_q : row_q + CW'(1);
          col_d = '0;
          idx_d = '0;
        end

        if (vsyn_rise) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          state_d      = mode_q ? ST_WAIT_FRAME : ST_DONE;
        end
      end

      ST_DONE: begin
        // Held until capture drops (handled by the abort path below).
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: capture low forces IDLE from any state and cancels any pending
    // pixel, partial pixel and frame_done.
    if (!capture) begin
      state_d      = ST_IDLE;
      col_d        = '0;
      row_d        = '0;
      idx_d        = '0;
      wr_pend_d    = 1'b0;
      fifo_wr_d    = 1'b0;
      fifo_data_d  = fifo_data_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      overflow_d   = overflow_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Pclk) begin
    // NOTE: non-blocking assignments make every flop sample the values from
    // before this edge, independent of statement order.
    if (rst) begin
      vsyn_s1_q    <= 1'b0;
      href_s1_q    <= 1'b0;
      data_s1_q    <= '0;
      vsyn_p_q     <= 1'b0;
      href_p_q     <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      pack_q       <= '0;
      wr_pend_q    <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_data_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vsyn_s1_q    <= vsyn_s1_d;
      href_s1_q    <= href_s1_d;
      data_s1_q    <= data_s1_d;
      vsyn_p_q     <= vsyn_p_d;
      href_p_q     <= href_p_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      pack_q       <= pack_d;
      wr_pend_q    <= wr_pend_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_data_q  <= fifo_data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fifo_wr    = fifo_wr_q;
  assign fifo_data  = fifo_data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign frame_cnt  = frame_cnt_q;
  assign PWDN       = ~capture;
  assign busy       = (state_q == ST_WAIT_VS) || (state_q == ST_WAIT_FRAME) ||
                      (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_cam_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_frame_capture
//
// Directed bench for cam_frame_capture. Two instances share the sensor-side
// stimulus: dut_f captures the full frame, dut_w has a 2x1 crop window at
// column 1, line 1. Frames are 4x3 pixels (8 bytes per line). Byte values
// are frame*64 + line*16 + byte_index, so every expected pixel is derived
// directly from its position.
// -----------------------------------------------------------------------------
module tb_cam_frame_capture;

  logic        Pclk = 1'b0;
  logic        rst;
  logic        capture;
  logic        mode;
  logic        Vsyn;
  logic        Href;
  logic [7:0]  data;
  logic        fifo_full;

  logic        fifo_wr_f, fifo_wr_w;
  logic [15:0] fifo_data_f, fifo_data_w;
  logic        pwdn_f, pwdn_w;
  logic        busy_f, busy_w;
  logic        frame_done_f, frame_done_w;
  logic        overflow_f, overflow_w;
  logic [7:0]  frame_cnt_f, frame_cnt_w;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] got_q[$];
  logic [15:0] got_w_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_w_q[$];
  int          fd_cnt    = 0;
  int          fd_double = 0;
  logic        fd_prev   = 1'b0;

  cam_frame_capture #(
    .DW(8), .BPP(2), .CW(11), .X0(0), .Y0(0), .WIN_W(640), .WIN_H(480)
  ) dut_f (
    .Pclk(Pclk), .rst(rst), .capture(capture), .mode(mode), .Vsyn(Vsyn),
    .Href(Href), .data(data), .fifo_full(fifo_full), .fifo_wr(fifo_wr_f),
    .fifo_data(fifo_data_f), .PWDN(pwdn_f), .busy(busy_f),
    .frame_done(frame_done_f), .overflow(overflow_f), .frame_cnt(frame_cnt_f)
  );

  cam_frame_capture #(
    .DW(8), .BPP(2), .CW(11), .X0(1), .Y0(1), .WIN_W(2), .WIN_H(1)
  ) dut_w (
    .Pclk(Pclk), .rst(rst), .capture(capture), .mode(mode), .Vsyn(Vsyn),
    .Href(Href), .data(data), .fifo_full(fifo_full), .fifo_wr(fifo_wr_w),
    .fifo_data(fifo_data_w), .PWDN(pwdn_w), .busy(busy_w),
    .frame_done(frame_done_w), .overflow(overflow_w), .frame_cnt(frame_cnt_w)
  );

  always #5 Pclk = ~Pclk;

  // Output recorder, sampling away from the rising edge.
  always @(negedge Pclk) begin
    if (!rst) begin
      if (fifo_wr_f) got_q.push_back(fifo_data_f);
      if (fifo_wr_w) got_w_q.push_back(fifo_data_w);
      if (frame_done_f) fd_cnt++;
      if (frame_done_f && fd_prev) fd_double++;
    end
    fd_prev = frame_done_f;
  end

  function automatic logic [7:0] byte_val(input int f, input int line, input int i);
    return 8'(f * 64 + line * 16 + i);
  endfunction

  function automatic logic [15:0] pix_val(input int f, input int line, input int p);
    return {byte_val(f, line, 2 * p), byte_val(f, line, 2 * p + 1)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge Pclk);
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_w_q.delete();
    exp_q.delete();
    exp_w_q.delete();
    fd_cnt    = 0;
    fd_double = 0;
  endtask

  task automatic vsync_pulse();
    @(negedge Pclk);
    Vsyn = 1'b1;
    cyc(4);
    Vsyn = 1'b0;
    cyc(3);
  endtask

  // One sensor line of nbytes bytes. lat_chk checks the write latency of the
  // first pixel; fifo_full is held high over two edges starting at byte
  // full_at; capture drops at byte abort_at (negative = unused).
  task automatic drive_line(input int f, input int line, input int nbytes,
                            input bit lat_chk, input int full_at, input int abort_at);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge Pclk);
      if (lat_chk && i == 3) begin
        vectors++;
        if (fifo_wr_f !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_early: fifo_wr=%b want 0", fifo_wr_f);
        end
      end
      if (lat_chk && i == 4) begin
        vectors++;
        if (fifo_wr_f !== 1'b1 || fifo_data_f !== 16'h0001) begin
          miscompares++;
          $display("FAIL latency_hit: fifo_wr=%b data=%h want 1/0001", fifo_wr_f, fifo_data_f);
        end
      end
      if (lat_chk && i == 5) begin
        vectors++;
        if (fifo_wr_f !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_one_cycle: fifo_wr=%b want 0", fifo_wr_f);
        end
      end
      if (i == full_at) fifo_full = 1'b1;
      if (full_at >= 0 && i == full_at + 2) fifo_full = 1'b0;
      if (i == abort_at) capture = 1'b0;
      Href = 1'b1;
      data = byte_val(f, line, i);
    end
    @(negedge Pclk);
    Href      = 1'b0;
    data      = 8'h00;
    fifo_full = 1'b0;
    cyc(3);
  endtask

  task automatic compare_logs(input string name);
    logic [15:0] g;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d writes want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      vectors++;
      if (g !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_pix%0d: got %h want %h", name, i, g, exp_q[i]);
      end
    end
  endtask

  task automatic compare_win_logs(input string name);
    logic [15:0] g;
    vectors++;
    if (got_w_q.size() != exp_w_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d writes want %0d", name, got_w_q.size(), exp_w_q.size());
    end
    for (int i = 0; i < exp_w_q.size(); i++) begin
      g = (i < got_w_q.size()) ? got_w_q[i] : 16'hxxxx;
      vectors++;
      if (g !== exp_w_q[i]) begin
        miscompares++;
        $display("FAIL %s_pix%0d: got %h want %h", name, i, g, exp_w_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; capture = 1'b1; mode = 1'b1;
    Vsyn = 1'b1; Href = 1'b1; data = 8'hff; fifo_full = 1'b0;
    cyc(4);
    vectors++;
    if ({fifo_wr_f, busy_f, frame_done_f, overflow_f} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: wr/busy/fd/ovf=%b want 0000",
               {fifo_wr_f, busy_f, frame_done_f, overflow_f});
    end
    vectors++;
    if (fifo_data_f !== 16'h0000 || frame_cnt_f !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: fifo_data=%h frame_cnt=%h want 0/0", fifo_data_f, frame_cnt_f);
    end
    vectors++;
    if (pwdn_f !== 1'b0) begin
      miscompares++;
      $display("FAIL pwdn_armed: PWDN=%b want 0", pwdn_f);
    end
    capture = 1'b0;
    #1;
    vectors++;
    if (pwdn_f !== 1'b1) begin
      miscompares++;
      $display("FAIL pwdn_idle: PWDN=%b want 1", pwdn_f);
    end
    Vsyn = 1'b0; Href = 1'b0; data = 8'h00;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    vectors++;
    if (busy_f !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy_f);
    end
  endtask

  // Single-frame mode over two sensor frames, full and cropped window.
  task automatic test_single_frame();
    clear_logs();
    mode = 1'b0;
    capture = 1'b1;
    cyc(3);
    vectors++;
    if (busy_f !== 1'b1) begin
      miscompares++;
      $display("FAIL armed_busy: busy=%b want 1", busy_f);
    end
    vsync_pulse();
    drive_line(0, 0, 8, 1'b1, -1, -1);
    drive_line(0, 1, 8, 1'b0, -1, -1);
    drive_line(0, 2, 8, 1'b0, -1, -1);
    vsync_pulse();
    for (int l = 0; l < 3; l++) drive_line(1, l, 8, 1'b0, -1, -1);
    vsync_pulse();
    cyc(4);
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 4; p++) exp_q.push_back(pix_val(0, l, p));
    compare_logs("single");
    exp_w_q.push_back(16'h1213);
    exp_w_q.push_back(16'h1415);
    compare_win_logs("window");
    vectors++;
    if (fd_cnt != 1 || fd_double != 0) begin
      miscompares++;
      $display("FAIL single_frame_done: pulses=%0d doubles=%0d want 1/0", fd_cnt, fd_double);
    end
    vectors++;
    if (frame_cnt_f !== 8'd1 || busy_f !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: frame_cnt=%0d busy=%b want 1/0", frame_cnt_f, busy_f);
    end
  endtask

  task automatic test_overflow();
    capture = 1'b0;
    cyc(2);
    capture = 1'b1;
    mode = 1'b0;
    cyc(2);
    clear_logs();
    vectors++;
    if (overflow_f !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_initial: overflow=%b want 0", overflow_f);
    end
    vsync_pulse();
    drive_line(0, 0, 8, 1'b0, -1, -1);
    drive_line(0, 1, 8, 1'b0, 4, -1);
    drive_line(0, 2, 8, 1'b0, -1, -1);
    vsync_pulse();
    cyc(4);
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 4; p++)
        if (!(l == 1 && p == 1)) exp_q.push_back(pix_val(0, l, p));
    compare_logs("overflow");
    vectors++;
    if (overflow_f !== 1'b1 || fd_cnt != 1) begin
      miscompares++;
      $display("FAIL overflow_set: overflow=%b frame_done=%0d want 1/1", overflow_f, fd_cnt);
    end
    capture = 1'b0;
    cyc(3);
    vectors++;
    if (overflow_f !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_held_idle: overflow=%b want 1", overflow_f);
    end
    capture = 1'b1;
    cyc(2);
    vectors++;
    if (overflow_f !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_rearm: overflow=%b want 0", overflow_f);
    end
  endtask

  task automatic test_continuous();
    rst = 1'b1;
    mode = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      for (int l = 0; l < 3; l++) drive_line(f, l, 8, 1'b0, -1, -1);
      vectors++;
      if (busy_f !== 1'b1) begin
        miscompares++;
        $display("FAIL cont_busy_f%0d: busy=%b want 1", f, busy_f);
      end
      for (int l = 0; l < 3; l++)
        for (int p = 0; p < 4; p++) exp_q.push_back(pix_val(f, l, p));
    end
    vsync_pulse();
    cyc(4);
    compare_logs("cont");
    vectors++;
    if (fd_cnt != 3 || fd_double != 0 || frame_cnt_f !== 8'd3) begin
      miscompares++;
      $display("FAIL cont_frames: pulses=%0d doubles=%0d frame_cnt=%0d want 3/0/3",
               fd_cnt, fd_double, frame_cnt_f);
    end
    vectors++;
    if (busy_f !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_busy_end: busy=%b want 1", busy_f);
    end
    capture = 1'b0;
    cyc(2);
    vectors++;
    if (busy_f !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_abort: busy=%b want 0", busy_f);
    end
  endtask

  task automatic test_mid_frame_arm_abort();
    capture = 1'b0;
    mode = 1'b0;
    cyc(3);
    clear_logs();
    vsync_pulse();
    drive_line(3, 0, 8, 1'b0, -1, -1);
    capture = 1'b1;
    cyc(1);
    vectors++;
    if (busy_f !== 1'b1) begin
      miscompares++;
      $display("FAIL midarm_busy: busy=%b want 1", busy_f);
    end
    drive_line(3, 1, 8, 1'b0, -1, -1);
    drive_line(3, 2, 8, 1'b0, -1, -1);
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL midarm_partial: got %0d writes want 0", got_q.size());
    end
    vsync_pulse();
    drive_line(3, 0, 8, 1'b0, -1, 5);
    vectors++;
    if (busy_f !== 1'b0 || pwdn_f !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b PWDN=%b want 0/1", busy_f, pwdn_f);
    end
    drive_line(3, 1, 8, 1'b0, -1, -1);
    drive_line(3, 2, 8, 1'b0, -1, -1);
    vsync_pulse();
    cyc(4);
    exp_q.push_back(16'hC0C1);
    compare_logs("abort");
    vectors++;
    if (fd_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_frame_done: pulses=%0d want 0", fd_cnt);
    end
  endtask

  task automatic test_odd_line();
    capture = 1'b0;
    cyc(2);
    capture = 1'b1;
    mode = 1'b0;
    cyc(2);
    clear_logs();
    vsync_pulse();
    drive_line(0, 0, 5, 1'b0, -1, -1);
    drive_line(0, 1, 8, 1'b0, -1, -1);
    vsync_pulse();
    cyc(4);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0203);
    exp_q.push_back(16'h1011);
    exp_q.push_back(16'h1213);
    exp_q.push_back(16'h1415);
    exp_q.push_back(16'h1617);
    compare_logs("odd");
    exp_w_q.push_back(16'h1213);
    exp_w_q.push_back(16'h1415);
    compare_win_logs("odd_window");
    vectors++;
    if (fd_cnt != 1) begin
      miscompares++;
      $display("FAIL odd_frame_done: pulses=%0d want 1", fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_continuous();
    test_mid_frame_arm_abort();
    test_odd_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
